// File: rtl/tdma_sched_pkg.sv
// tdma_sched_pkg: shared definitions for the TDMA slot scheduler.
//   Register offsets (REG_CTRL..REG_STATUS), CTRL/STATUS bit indices and
//   the scheduler FSM state type (ST_IDLE, ST_RUN).
package tdma_sched_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_SLOT_LEN  = 2'd1;
  localparam logic [1:0] REG_NUM_SLOTS = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_RESYNC     = 2;
  localparam int unsigned STATUS_IRQ_PEND = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tdma_slot_timer.sv
// tdma_slot_timer: cycle/slot/frame counters with slot and frame strobes.
//   clk, reset_n      clock, asynchronous active-low reset
//   run_i             counters live; low forces all counters and strobes to 0
//   restart_i         jump to cycle 0 of slot 0 with both strobes (frame count kept)
//   len_i, nslots_i   active slot length and slot count (both minus 1)
//   slot_o, frame_cnt_o, slot_start_o, frame_start_o   registered outputs
//   cyc_nxt_o, slot_nxt_o, frame_start_nxt_o           next-state values, so the
//                     parent can register outputs aligned with the counters
//   frame_end_o       last cycle of the last slot of the current frame
module tdma_slot_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_i,
  input  logic        restart_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  nslots_i,
  output logic [7:0]  slot_o,
  output logic [15:0] frame_cnt_o,
  output logic        slot_start_o,
  output logic        frame_start_o,
  output logic [15:0] cyc_nxt_o,
  output logic [7:0]  slot_nxt_o,
  output logic        frame_start_nxt_o,
  output logic        frame_end_o
);

  logic [15:0] cyc_q, cyc_d;
  logic [7:0]  slot_q, slot_d;
  logic [15:0] frame_q, frame_d;
  logic        ss_q, ss_d;
  logic        fs_q, fs_d;

  assign frame_end_o = (cyc_q == len_i) && (slot_q == nslots_i);

  always_comb begin
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    ss_d    = 1'b0;
    fs_d    = 1'b0;
    if (!run_i) begin
      cyc_d   = '0;
      slot_d  = '0;
      frame_d = '0;
    end else if (restart_i) begin
      cyc_d  = '0;
      slot_d = '0;
      ss_d   = 1'b1;
      fs_d   = 1'b1;
    end else if (cyc_q == len_i) begin
      cyc_d = '0;
      ss_d  = 1'b1;
      if (slot_q == nslots_i) begin
        slot_d  = '0;
        frame_d = frame_q + 16'd1;
        fs_d    = 1'b1;
      end else begin
        slot_d = slot_q + 8'd1;
      end
    end else begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      ss_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      ss_q    <= ss_d;
      fs_q    <= fs_d;
    end
  end

  assign slot_o            = slot_q;
  assign frame_cnt_o       = frame_q;
  assign slot_start_o      = ss_q;
  assign frame_start_o     = fs_q;
  assign cyc_nxt_o         = cyc_d;
  assign slot_nxt_o        = slot_d;
  assign frame_start_nxt_o = fs_d;

endmodule

// File: rtl/tdma_slot_scheduler.sv
// tdma_slot_scheduler: TDMA receive-schedule sequencer with Avalon-MM register file.
//   clk, reset_n   clock, asynchronous active-low reset
//   address, write, writedata, readdata   4x32-bit slave, readdata registered every clk
//   recv_addr      current slot index (to tdma_recv_addr PIO)
//   tx_grant       own slot active, outside the guard band at slot end
//   slot_start     first cycle of each slot; frame_start first cycle of slot 0
//   irq            frame interrupt, only when TDMA_SCHED_IRQ_EN is defined
// Register writes act on the clock edge that samples them, so enable/disable and
// resync reach the counters without an extra cycle of delay.
module tdma_slot_scheduler
  import tdma_sched_pkg::*;
#(
  parameter logic [15:0] SLOT_LEN_DEF  = 16'd999,
  parameter logic [7:0]  NUM_SLOTS_DEF = 8'd7,
  parameter int unsigned GUARD         = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  recv_addr,
  output logic        tx_grant,
  output logic        slot_start,
  output logic        frame_start,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [15:0] len_sh_q, len_sh_d, len_q, len_d;
  logic [7:0]  ns_sh_q, ns_sh_d, ns_q, ns_d;
  logic [7:0]  own_q, own_d;
  logic        tx_grant_q, tx_grant_d;
  logic [31:0] rd_q, rd_d;
  logic        wr_ctrl, wr_len, wr_ns, wr_status, resync, run, restart, load;
  logic [7:0]  slot, slot_nxt;
  logic [15:0] frame_cnt, cyc_nxt;
  logic        fs_nxt, frame_end;
  logic        irq_en_rd, irq_pend_rd;
  logic        unused_bits;

  assign unused_bits = ^{writedata[31:16], fs_nxt};

  assign wr_ctrl   = write && (address == REG_CTRL);
  assign wr_len    = write && (address == REG_SLOT_LEN);
  assign wr_ns     = write && (address == REG_NUM_SLOTS);
  assign wr_status = write && (address == REG_STATUS);
  assign resync    = wr_ctrl && writedata[CTRL_RESYNC];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_d)  state_d = ST_RUN;
      ST_RUN:  if (!en_d) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A disabling write drops run, so it overrides a resync in the same write.
  assign run     = (state_d == ST_RUN);
  assign restart = run && ((state_q == ST_IDLE) || resync);
  assign load    = restart || (run && frame_end);

  always_comb begin
    en_d     = wr_ctrl ? writedata[CTRL_ENABLE] : en_q;
    len_sh_d = wr_len ? writedata[15:0] : len_sh_q;
    ns_sh_d  = wr_ns ? writedata[7:0] : ns_sh_q;
    own_d    = wr_ns ? writedata[15:8] : own_q;
    len_d    = load ? len_sh_d : len_q;
    ns_d     = load ? ns_sh_d : ns_q;
    // Widened so len+1 <= GUARD yields no grant instead of wrapping.
    tx_grant_d = run && (slot_nxt == own_d) &&
                 (({2'b00, cyc_nxt} + 18'(GUARD)) < ({2'b00, len_d} + 18'd1));
  end

  always_comb begin
    rd_d = '0;
    case (address)
      REG_CTRL: begin
        rd_d[CTRL_ENABLE] = en_q;
        rd_d[CTRL_IRQ_EN] = irq_en_rd;
      end
      REG_SLOT_LEN:  rd_d[15:0] = len_sh_q;
      REG_NUM_SLOTS: rd_d[15:0] = {own_q, ns_sh_q};
      default: begin
        rd_d[7:0]             = slot;
        rd_d[23:8]            = frame_cnt;
        rd_d[STATUS_IRQ_PEND] = irq_pend_rd;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      len_sh_q   <= SLOT_LEN_DEF;
      ns_sh_q    <= NUM_SLOTS_DEF;
      len_q      <= SLOT_LEN_DEF;
      ns_q       <= NUM_SLOTS_DEF;
      own_q      <= '0;
      tx_grant_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      len_sh_q   <= len_sh_d;
      ns_sh_q    <= ns_sh_d;
      len_q      <= len_d;
      ns_q       <= ns_d;
      own_q      <= own_d;
      tx_grant_q <= tx_grant_d;
      rd_q       <= rd_d;
    end
  end

  tdma_slot_timer u_timer (
    .clk               (clk),
    .reset_n           (reset_n),
    .run_i             (run),
    .restart_i         (restart),
    .len_i             (len_q),
    .nslots_i          (ns_q),
    .slot_o            (slot),
    .frame_cnt_o       (frame_cnt),
    .slot_start_o      (slot_start),
    .frame_start_o     (frame_start),
    .cyc_nxt_o         (cyc_nxt),
    .slot_nxt_o        (slot_nxt),
    .frame_start_nxt_o (fs_nxt),
    .frame_end_o       (frame_end)
  );

`ifdef TDMA_SCHED_IRQ_EN
  logic irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_q;

  always_comb begin
    irq_en_d   = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;
    irq_pend_d = irq_pend_q;
    if (wr_status && writedata[STATUS_IRQ_PEND]) irq_pend_d = 1'b0;
    // A frame start on the clearing cycle keeps the interrupt pending.
    if (run && fs_nxt) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_pend_d & irq_en_d;
    end
  end

  assign irq         = irq_q;
  assign irq_en_rd   = irq_en_q;
  assign irq_pend_rd = irq_pend_q;
`else
  assign irq         = 1'b0;
  assign irq_en_rd   = 1'b0;
  assign irq_pend_rd = 1'b0;
`endif

  assign readdata  = rd_q;
  assign recv_addr = slot;
  assign tx_grant  = tx_grant_q;

endmodule

// File: tb/tb_tdma_slot_scheduler.sv
module tb_tdma_slot_scheduler;

  localparam int unsigned GUARD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd3;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  recv_addr;
  logic        tx_grant, slot_start, frame_start, irq;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdma_slot_scheduler #(
    .SLOT_LEN_DEF  (16'd999),
    .NUM_SLOTS_DEF (8'd7),
    .GUARD         (GUARD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .recv_addr   (recv_addr),
    .tx_grant    (tx_grant),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .irq         (irq)
  );

  // Reference model: while running, position follows from elapsed cycles
  // since the start of the current configuration segment.
  int unsigned t, seg_t0, seg_f0;
  int unsigned m_len, m_ns, p_len, p_ns, m_own;
  bit          m_en, m_run, m_irq_en, m_pend;
  int unsigned e_slot, e_cyc, e_frame;
  bit          e_ss, e_fs, e_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic eval();
    int unsigned L, P, rel;
    if (!m_run) begin
      e_slot = 0; e_cyc = 0; e_frame = 0; e_ss = 0; e_fs = 0; e_grant = 0;
      return;
    end
    L = m_len + 1;
    P = L * (m_ns + 1);
    rel = t - seg_t0;
    e_cyc   = rel % L;
    e_slot  = (rel / L) % (m_ns + 1);
    e_frame = (seg_f0 + rel / P) % 65536;
    e_ss    = (e_cyc == 0);
    e_fs    = (rel % P == 0);
    e_grant = (e_slot == m_own) && (e_cyc + GUARD < L);
  endtask

  task automatic advance(input bit rs);
    int unsigned P, rel, fprev;
    fprev = e_frame;
    t++;
    P = (m_len + 1) * (m_ns + 1);
    rel = t - seg_t0;
    if (rs) begin
      seg_t0 = t; seg_f0 = fprev; m_len = p_len; m_ns = p_ns;
    end else if (rel % P == 0) begin
      seg_f0 = seg_f0 + rel / P; seg_t0 = t; m_len = p_len; m_ns = p_ns;
    end
  endtask

  task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd_exp;
    bit new_en, rs, w1c;
    rd_exp = '0;
    case (a)
      2'd0: begin rd_exp[0] = m_en; rd_exp[1] = m_irq_en; end
      2'd1: rd_exp[15:0] = p_len[15:0];
      2'd2: rd_exp[15:0] = {m_own[7:0], p_ns[7:0]};
      default: begin
        rd_exp[7:0]  = e_slot[7:0];
        rd_exp[23:8] = e_frame[15:0];
        rd_exp[31]   = m_pend;
      end
    endcase
    address = a; write = wr; writedata = d;
    @(posedge clk); #1;
    write = 1'b0; address = 2'd3; writedata = '0;
    new_en = m_en; rs = 0; w1c = 0;
    if (wr && a == 2'd0) begin
      new_en = d[0]; rs = d[2];
`ifdef TDMA_SCHED_IRQ_EN
      m_irq_en = d[1];
`endif
    end
    if (wr && a == 2'd1) p_len = d[15:0];
    if (wr && a == 2'd2) begin p_ns = d[7:0]; m_own = d[15:8]; end
    if (wr && a == 2'd3) w1c = d[31];
    if (!new_en) m_run = 0;
    else if (!m_run) begin
      m_run = 1; t = 0; seg_t0 = 0; seg_f0 = 0; m_len = p_len; m_ns = p_ns;
    end else advance(rs);
    m_en = new_en;
    eval();
`ifdef TDMA_SCHED_IRQ_EN
    if (m_run && e_fs) m_pend = 1;
    else if (w1c) m_pend = 0;
`endif
    check("readdata", readdata, rd_exp);
    check("recv_addr", {24'b0, recv_addr}, e_slot);
    check("slot_start", {31'b0, slot_start}, {31'b0, e_ss});
    check("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
    check("tx_grant", {31'b0, tx_grant}, {31'b0, e_grant});
    check("irq", {31'b0, irq}, {31'b0, m_pend & m_irq_en});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd3, 32'h0);
  endtask

  initial begin
    int unsigned len, ns, own, ncyc, r, P;
    t = 0; seg_t0 = 0; seg_f0 = 0; m_len = 999; m_ns = 7; p_len = 999; p_ns = 7;
    m_own = 0; m_en = 0; m_run = 0; m_irq_en = 0; m_pend = 0;
    eval();
    #22 reset_n = 1'b1;
    #1;
    check("rst_recv_addr", {24'b0, recv_addr}, 32'h0);
    check("rst_strobes", {29'b0, slot_start, frame_start, tx_grant}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);

    // Reset register values.
    cycle(1'b0, 2'd0, 32'h0);
    cycle(1'b0, 2'd1, 32'h0);
    cycle(1'b0, 2'd2, 32'h0);
    cycle(1'b0, 2'd3, 32'h0);

    // len=3, nslots=2: 4-cycle slots, 12-cycle frames.
    wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd0, 32'h1);
    idle(30);
    // New length waits for the next frame boundary.
    wr(2'd1, 32'd7);
    idle(40);
    // Disable mid-slot.
    idle(3);
    wr(2'd0, 32'h0);
    idle(3);

    // Own slot 1, len=9: grant at cyc 0..5 of slot 1.
    wr(2'd2, 32'h0102); wr(2'd1, 32'd9); wr(2'd0, 32'h1);
    idle(70);
    // Resync mid-frame, then resync together with disable.
    idle(7);
    wr(2'd0, 32'h5);
    idle(40);
    wr(2'd0, 32'h4);
    idle(3);

    // 1-cycle slots, single-slot frame; own address beyond slot count.
    wr(2'd1, 32'd0); wr(2'd2, 32'h0500); wr(2'd0, 32'h1);
    idle(10);
    wr(2'd0, 32'h0);
    // len+1 <= GUARD: never granted.
    wr(2'd1, 32'd2); wr(2'd2, 32'h0001); wr(2'd0, 32'h1);
    idle(20);
    wr(2'd0, 32'h0);

    // Interrupt enable, W1C off a boundary and on a frame_start edge.
    wr(2'd1, 32'd3); wr(2'd2, 32'h0000); wr(2'd0, 32'h3);
    idle(6);
    wr(2'd3, 32'h8000_0000);
    idle(2);
    P = (m_len + 1) * (m_ns + 1);
    for (int i = 0; i < 20; i++) begin
      if ((t + 1 - seg_t0) % P == 0) break;
      idle(1);
    end
    wr(2'd3, 32'h8000_0000);
    idle(3);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h8000_0000);
    idle(2);

    // Randomized rounds with random register traffic while running.
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(0, 7);
      ns  = $urandom_range(0, 3);
      own = $urandom_range(0, 4);
      wr(2'd1, len);
      wr(2'd2, {16'b0, own[7:0], ns[7:0]});
      wr(2'd0, 32'h1 | ($urandom_range(0, 1) << 1));
      ncyc = $urandom_range(40, 100);
      for (int c = 0; c < int'(ncyc); c++) begin
        r = $urandom_range(0, 99);
        if (r < 4) wr(2'd1, $urandom_range(0, 7));
        else if (r < 7) begin
          own = $urandom_range(0, 4);
          ns  = $urandom_range(0, 3);
          wr(2'd2, {16'b0, own[7:0], ns[7:0]});
        end
        else if (r < 9) wr(2'd0, 32'h5 | ($urandom_range(0, 1) << 1));
        else if (r < 12) wr(2'd3, 32'h8000_0000);
        else idle(1);
      end
      wr(2'd0, 32'h0);
      idle(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
